// File: rtl/alu_pkg.sv
// Shared definitions for the parameterised ALU: opcode encodings, FSM state
// encodings and the packed NZCV flag record.
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_ORR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_EOR = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_MOV = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
// Ports:
//   clk, rst       clock, async active-high reset
//   start          load operands and begin (ignored result of any prior run)
//   op_a, op_b     multiplicand / multiplier
//   done           high on the cycle the last bit is processed
//   result         low WIDTH bits of op_a*op_b, valid while done is high
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             active_q, active_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] sum;

  always_comb begin
    // The final partial product is folded in combinationally so the result
    // is ready on the same edge the counter reaches its last bit.
    sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
    done     = active_q && (cnt_q == LAST);
    result   = sum;
    active_d = active_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = op_a;
      mplier_d = op_b;
    end else if (active_q) begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (done) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/param_alu_unit.sv
// Parameterised ALU with valid/ready handshake, registered NZCV flags and an
// optional iterative multiplier.
// Ports:
//   clk, rst                     clock, async active-high reset
//   in_valid/in_ready            operation handshake
//   control, operand1, operand2  opcode and operands
//   set_flags                    update NZCV from this op
//   out_valid/out_ready          result handshake
//   out_data, out_wb, out_illegal  held result and its attributes
//   negative/zero/carry/overflow_flag  registered NZCV
//
// state | meaning
// IDLE  | accepting ops; single-cycle results load directly to the output
// BUSY  | shift-add multiply in progress, in_ready held low
module param_alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_wb,
  output logic             out_illegal,
  output logic             negative_flag,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             overflow_flag
);

  logic [0:0]       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_wb_q, out_wb_d;
  logic             out_illegal_q, out_illegal_d;
  nzcv_t            flags_q, flags_d;
  logic             mul_sf_q, mul_sf_d;

  logic             accept, is_mul, mul_start, mul_done, load_single;
  logic [WIDTH-1:0] mul_result;
  logic             sub, cin;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   sum_ext;
  logic             v_arith;
  logic [WIDTH-1:0] s_res;
  logic             s_wb, s_ill, s_flag_en, s_cv_en;

  assign in_ready    = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign is_mul      = (MUL_EN == 1'b1) && (control == OP_MUL);
  assign mul_start   = accept && is_mul;
  assign load_single = accept && !is_mul;

  always_comb begin
    sub = 1'b0;
    cin = 1'b0;
    case (control)
      OP_ADC:         cin = flags_q.c;
      OP_SUB, OP_CMP: begin sub = 1'b1; cin = 1'b1; end
      // op1 - op2 - !C == op1 + ~op2 + C
      OP_SBC:         begin sub = 1'b1; cin = flags_q.c; end
      default:        ;
    endcase
  end

  // Subtraction reuses the adder with an inverted operand, so the carry out
  // is directly NOT borrow and one overflow rule covers both directions.
  assign b_x     = sub ? ~operand2 : operand2;
  assign sum_ext = {1'b0, operand1} + {1'b0, b_x} + {{WIDTH{1'b0}}, cin};
  assign v_arith = (operand1[WIDTH-1] == b_x[WIDTH-1]) &&
                   (sum_ext[WIDTH-1] != operand1[WIDTH-1]);

  always_comb begin
    s_res     = sum_ext[WIDTH-1:0];
    s_wb      = 1'b1;
    s_ill     = 1'b0;
    s_flag_en = 1'b1;
    s_cv_en   = 1'b1;
    case (control)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: ;
      OP_CMP: s_wb = 1'b0;
      OP_AND: begin s_res = operand1 & operand2; s_cv_en = 1'b0; end
      OP_ORR: begin s_res = operand1 | operand2; s_cv_en = 1'b0; end
      OP_EOR: begin s_res = operand1 ^ operand2; s_cv_en = 1'b0; end
      OP_MOV: begin s_res = operand2;            s_cv_en = 1'b0; end
      OP_NOP: begin
        s_res     = out_data_q;
        s_wb      = 1'b0;
        s_flag_en = 1'b0;
      end
      // Undefined codes, and MUL when the multiplier is compiled out.
      default: begin
        s_res     = '0;
        s_wb      = 1'b0;
        s_ill     = 1'b1;
        s_flag_en = 1'b0;
      end
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .op_a   (operand1),
    .op_b   (operand2),
    .done   (mul_done),
    .result (mul_result)
  );

  always_comb begin
    state_d       = state_q;
    mul_sf_d      = mul_sf_q;
    out_valid_d   = out_ready ? 1'b0 : out_valid_q;
    out_data_d    = out_data_q;
    out_wb_d      = out_wb_q;
    out_illegal_d = out_illegal_q;
    flags_d       = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (mul_start) begin
          state_d  = ST_BUSY;
          mul_sf_d = set_flags;
        end
        if (load_single) begin
          out_valid_d   = 1'b1;
          out_data_d    = s_res;
          out_wb_d      = s_wb;
          out_illegal_d = s_ill;
          if (set_flags && s_flag_en) begin
            flags_d.n = s_res[WIDTH-1];
            flags_d.z = (s_res == '0);
            if (s_cv_en) begin
              flags_d.c = sum_ext[WIDTH];
              flags_d.v = v_arith;
            end
          end
        end
      end
      default: begin
        if (mul_done) begin
          state_d       = ST_IDLE;
          out_valid_d   = 1'b1;
          out_data_d    = mul_result;
          out_wb_d      = 1'b1;
          out_illegal_d = 1'b0;
          if (mul_sf_q) begin
            flags_d.n = mul_result[WIDTH-1];
            flags_d.z = (mul_result == '0);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mul_sf_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_wb_q      <= 1'b0;
      out_illegal_q <= 1'b0;
      flags_q       <= '0;
    end else begin
      state_q       <= state_d;
      mul_sf_q      <= mul_sf_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_wb_q      <= out_wb_d;
      out_illegal_q <= out_illegal_d;
      flags_q       <= flags_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_wb        = out_wb_q;
  assign out_illegal   = out_illegal_q;
  assign negative_flag = flags_q.n;
  assign zero_flag     = flags_q.z;
  assign carry_flag    = flags_q.c;
  assign overflow_flag = flags_q.v;

endmodule

// File: tb/tb_param_alu_unit.sv
module tb_param_alu_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [3:0]   control;
  logic [W-1:0] operand1, operand2;
  logic         set_flags;
  logic         out_valid, out_ready;
  logic [W-1:0] out_data;
  logic         out_wb, out_illegal;
  logic         negative_flag, zero_flag, carry_flag, overflow_flag;

  param_alu_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .control       (control),
    .operand1      (operand1),
    .operand2      (operand2),
    .set_flags     (set_flags),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_wb        (out_wb),
    .out_illegal   (out_illegal),
    .negative_flag (negative_flag),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    logic         wb;
    logic         ill;
    logic [3:0]   nzcv;
    int           acc;
    int           dly;
    string        name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [3:0] nzcv_now();
    return {negative_flag, zero_flag, carry_flag, overflow_flag};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every transfer pops one expected record and compares it.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = q.pop_front();
        chk({e.name, "_data"},    64'(out_data),    64'(e.data));
        chk({e.name, "_wb"},      64'(out_wb),      64'(e.wb));
        chk({e.name, "_illegal"}, 64'(out_illegal), 64'(e.ill));
        chk({e.name, "_nzcv"},    64'(nzcv_now()),  64'(e.nzcv));
        if (e.dly >= 0) chk({e.name, "_latency"}, 64'(cyc - e.acc), 64'(e.dly));
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sf, input logic [W-1:0] ed, input logic ewb,
                       input logic eill, input logic [3:0] enzcv, input int dly,
                       input string nm);
    exp_t e;
    bit   got;
    got = 1'b0;
    @(negedge clk);
    in_valid  = 1'b1;
    control   = op;
    operand1  = a;
    operand2  = b;
    set_flags = sf;
    for (int i = 0; i < 200 && !got; i++) begin
      #1;
      if (in_ready) begin
        got    = 1'b1;
        e.data = ed; e.wb = ewb; e.ill = eill; e.nzcv = enzcv;
        e.acc  = cyc + 1; e.dly = dly; e.name = nm;
        q.push_back(e);
      end else begin
        @(negedge clk);
      end
    end
    if (!got) chk({nm, "_accept_timeout"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    #2;
    chk({nm, "_drain"}, 64'(q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_hi;
    rst       = 1'b1;
    in_valid  = 1'b0;
    control   = OP_NOP;
    operand1  = '0;
    operand2  = '0;
    set_flags = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid",   64'(out_valid),   64'd0);
    chk("rst_out_data",    64'(out_data),    64'd0);
    chk("rst_out_wb",      64'(out_wb),      64'd0);
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    chk("rst_nzcv",        64'(nzcv_now()),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h0, 1'b1, 1'b0, 4'b0110, 0, "add_wrap");
    issue(OP_SUB, 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 4'b0011, 0, "sub_ovf");
    issue(4'b1111, 32'h1234, 32'h5678, 1'b1, 32'h0, 1'b0, 1'b1, 4'b0011, 0, "illegal");
    issue(OP_EOR, 32'hFF00, 32'h0FF0, 1'b0, 32'hF0F0, 1'b1, 1'b0, 4'b0011, 0, "eor_nf");
    issue(OP_ADC, 32'h1, 32'h1, 1'b1, 32'h3, 1'b1, 1'b0, 4'b0000, 0, "adc_c1");
    issue(OP_SBC, 32'h5, 32'h3, 1'b1, 32'h1, 1'b1, 1'b0, 4'b0010, 0, "sbc_c0");
    issue(OP_MOV, 32'h0, 32'hABCD, 1'b0, 32'hABCD, 1'b1, 1'b0, 4'b0010, 0, "mov");
    issue(OP_NOP, 32'h9, 32'h9, 1'b1, 32'hABCD, 1'b0, 1'b0, 4'b0010, 0, "nop");

    issue(OP_MUL, 32'h0001_0000, 32'h0001_0001, 1'b1, 32'h0001_0000, 1'b1, 1'b0,
          4'b0010, W, "mul");
    busy_hi = 0;
    repeat (W) begin
      @(negedge clk);
      #1;
      if (in_ready !== 1'b0) busy_hi++;
    end
    chk("mul_busy_in_ready_high_cycles", 64'(busy_hi), 64'd0);
    wait_drain("mul");

    @(negedge clk);
    out_ready = 1'b0;
    issue(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 1'b1, 1'b0,
          4'b1010, -1, "and_stall");
    fork
      issue(OP_ORR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hFFF0_FFF0, 1'b1, 1'b0,
            4'b1010, 0, "orr_after_stall");
      begin
        repeat (4) begin
          @(negedge clk);
          #1;
          chk("stall_hold_data", 64'(out_data),  64'hF000_F000);
          chk("stall_in_ready",  64'(in_ready),  64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_drain("stall");

    issue(OP_MUL, 32'h3, 32'h4, 1'b0, 32'hC, 1'b1, 1'b0, 4'b1010, W, "mul_reset");
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midmul_rst_out_valid", 64'(out_valid),  64'd0);
    chk("midmul_rst_nzcv",      64'(nzcv_now()), 64'd0);
    chk("midmul_rst_out_data",  64'(out_data),   64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    issue(OP_CMP, 32'h5, 32'h5, 1'b1, 32'h0, 1'b0, 1'b0, 4'b0110, 0, "cmp_eq");
    wait_drain("final");
    repeat (W + 4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
